// File: rtl/c2c_pkg.sv
// Shared constants, FSM encoding and sizing helpers for the chip-to-chip
// link arbiter slice.
package c2c_pkg;

  // Payload width of one requester slot and of the link data bus.
  localparam int DATA_W = 3;

  // Baseline width of the hold and timeout counters.
  localparam int CNT_W = 27;

  // Link FSM encoding.
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_SEND = 2'd3;

  // Counter width for an interval of max_count cycles. The counter only
  // ever holds 0..max_count-1; the baseline width is kept as a floor and
  // widened when an interval would not fit.
  function automatic int cnt_width(input int unsigned max_count);
    int w;
    w = $clog2(max_count);
    return (w > CNT_W) ? w : CNT_W;
  endfunction

  // Width of an index into n requesters, never below one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/c2c_rr_pick.sv
// Round-robin picker: first pending requester at or after rr_ptr_i,
// searching upward with wrap. Purely combinational.
module c2c_rr_pick
  import c2c_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = ptr_width(N_REQ)
) (
  input  logic [N_REQ-1:0] pending_i,
  input  logic [PTR_W-1:0] rr_ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic             valid_o
);

  logic             found;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  // Walk the requesters starting at the pointer, grant the first one set.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned; a missing default here would infer a latch.
    grant_o = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      // rr_ptr_i < N_REQ and i < N_REQ, so one subtraction is enough to wrap.
      sum = {1'b0, rr_ptr_i} + (PTR_W + 1)'(i);
      if (sum >= (PTR_W + 1)'(N_REQ)) begin
        sum = sum - (PTR_W + 1)'(N_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (!found && pending_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  assign valid_o = |pending_i;

endmodule

// File: rtl/c2c_link_arbiter.sv
// Arbitrates N_REQ requesters onto one master-side chip-to-chip link.
// Handshake: request2s until ack, a HOLD interval with the notice LED lit,
// then SEND with valid until the slave drops ack. Each ack wait is bounded
// by a timeout that aborts the transaction without a done pulse.
module c2c_link_arbiter
  import c2c_pkg::*;
#(
  parameter int          N_REQ          = 4,
  parameter int unsigned HOLD_CYCLES    = 100000000,
  parameter int unsigned TIMEOUT_CYCLES = 200000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [DATA_W*N_REQ-1:0] req_data,
  input  logic                    ack,
  output logic                    request2s,
  output logic [DATA_W-1:0]       data,
  output logic                    valid,
  output logic                    notice,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic                    timeout_err,
  output logic                    busy
);

  localparam int PTR_W  = ptr_width(N_REQ);
  localparam int HOLD_W = cnt_width(HOLD_CYCLES);
  localparam int TO_W   = cnt_width(TIMEOUT_CYCLES);

  // Terminal counts: a counter that starts at 0 on state entry and reaches
  // these values has spent exactly the configured number of cycles.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  state_t              state_q,       state_d;
  logic [N_REQ-1:0]    pending_q,     pending_d;
  logic [PTR_W-1:0]    rr_ptr_q,      rr_ptr_d;
  logic [PTR_W-1:0]    owner_q,       owner_d;
  logic [N_REQ-1:0]    grant_q,       grant_d;
  logic                request2s_q,   request2s_d;
  logic [DATA_W-1:0]   data_q,        data_d;
  logic                valid_q,       valid_d;
  logic                notice_q,      notice_d;
  logic [N_REQ-1:0]    done_q,        done_d;
  logic                timeout_err_q, timeout_err_d;
  logic                busy_q,        busy_d;
  logic [HOLD_W-1:0]   hold_cnt_q,    hold_cnt_d;
  logic [TO_W-1:0]     to_cnt_q,      to_cnt_d;

  logic [N_REQ-1:0]    pick_grant;
  logic                pick_valid;
  logic [PTR_W-1:0]    pick_idx;
  logic [PTR_W-1:0]    next_ptr;
  logic [DATA_W-1:0]   owner_data;
  logic                abort;

  c2c_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .pending_i (pending_q),
    .rr_ptr_i  (rr_ptr_q),
    .grant_o   (pick_grant),
    .valid_o   (pick_valid)
  );

  // Convert the one-hot pick into the owner index kept for the transaction.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_grant[i]) begin
        pick_idx = PTR_W'(i);
      end
    end
  end

  // Select the owner's payload slice for latching on SEND entry.
  always_comb begin
    owner_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == PTR_W'(i)) begin
        owner_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Round-robin pointer moves just past the owner on any return to IDLE.
  assign next_ptr = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);

  // Next-state logic for the link FSM, pending set and every output.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q | req;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    grant_d       = grant_q;
    request2s_d   = request2s_q;
    data_d        = data_q;
    valid_d       = valid_q;
    notice_d      = notice_q;
    done_d        = '0;
    timeout_err_d = 1'b0;
    hold_cnt_d    = hold_cnt_q;
    to_cnt_d      = to_cnt_q;
    abort         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // ack is deliberately not looked at here.
        if (pick_valid) begin
          state_d     = ST_REQ;
          owner_d     = pick_idx;
          grant_d     = pick_grant;
          // Clearing after the OR absorbs a same-cycle pulse from the winner.
          pending_d   = (pending_q | req) & ~pick_grant;
          request2s_d = 1'b1;
          to_cnt_d    = '0;
        end
      end

      ST_REQ: begin
        if (ack) begin
          state_d     = ST_HOLD;
          request2s_d = 1'b0;
          notice_d    = 1'b1;
          hold_cnt_d  = '0;
        end else if (to_cnt_q == TO_LAST) begin
          abort = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d  = ST_SEND;
          notice_d = 1'b0;
          valid_d  = 1'b1;
          data_d   = owner_data;
          to_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      ST_SEND: begin
        if (!ack) begin
          state_d  = ST_IDLE;
          valid_d  = 1'b0;
          grant_d  = '0;
          done_d   = grant_q;
          rr_ptr_d = next_ptr;
        end else if (to_cnt_q == TO_LAST) begin
          abort = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A timed-out wait drops the link but leaves data at its last value.
    if (abort) begin
      state_d       = ST_IDLE;
      request2s_d   = 1'b0;
      valid_d       = 1'b0;
      notice_d      = 1'b0;
      grant_d       = '0;
      timeout_err_d = 1'b1;
      rr_ptr_d      = next_ptr;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pending_q     <= '0;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      grant_q       <= '0;
      request2s_q   <= 1'b0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      notice_q      <= 1'b0;
      done_q        <= '0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
      hold_cnt_q    <= '0;
      to_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      grant_q       <= grant_d;
      request2s_q   <= request2s_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      notice_q      <= notice_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
      hold_cnt_q    <= hold_cnt_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  assign request2s   = request2s_q;
  assign data        = data_q;
  assign valid       = valid_q;
  assign notice      = notice_q;
  assign grant       = grant_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_c2c_link_arbiter.sv
// Scoreboard bench for c2c_link_arbiter: stimulus queues the expected
// transaction record, a slave model answers the handshake, and a monitor
// measures each transaction and compares it when done/timeout_err fires.
module tb_c2c_link_arbiter;

  localparam int N   = 4;
  localparam int HC  = 4;
  localparam int TOC = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [3*N-1:0] req_data;
  logic           ack = 1'b0;
  logic           request2s;
  logic [2:0]     data;
  logic           valid;
  logic           notice;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           timeout_err;
  logic           busy;

  always #5 clk = ~clk;

  c2c_link_arbiter #(
    .N_REQ          (N),
    .HOLD_CYCLES    (HC),
    .TIMEOUT_CYCLES (TOC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .request2s   (request2s),
    .data        (data),
    .valid       (valid),
    .notice      (notice),
    .grant       (grant),
    .done        (done),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  typedef struct {
    int       owner;
    logic [2:0] dat;
    bit       timed_out;
    int       r2s;
    int       ntc;
    int       vld;
    int       gap;   // idle cycles since previous completion, -1 = unchecked
  } txn_t;

  typedef struct {
    int rise;        // request2s cycles before ack rises, 0 = never ack
    int fall;        // valid cycles before ack falls
  } slave_t;

  txn_t   exp_q[$];
  slave_t slv_q[$];
  int     errors = 0;
  int     checks = 0;

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Queue one expected transaction plus the slave behaviour that drives it.
  task automatic expect_txn(input int owner, input logic [2:0] d, input bit to,
                            input int r2s, input int ntc, input int vld,
                            input int gap, input int rise, input int fall);
    txn_t   t;
    slave_t s;
    t.owner = owner; t.dat = d; t.timed_out = to;
    t.r2s = r2s; t.ntc = ntc; t.vld = vld; t.gap = gap;
    s.rise = rise; s.fall = fall;
    exp_q.push_back(t);
    slv_q.push_back(s);
  endtask

  task automatic pulse(input logic [N-1:0] mask);
    req = mask;
    @(negedge clk);
    req = '0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 500; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    check({name, "_drained"}, 64'(k < 500), 1);
    @(negedge clk);
  endtask

  // which: 0 = notice, 1 = valid
  task automatic wait_sig(input int which, input string name);
    int   k;
    logic s;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      s = (which == 0) ? notice : valid;
      if (s) break;
    end
    check({name, "_seen"}, 64'(k < 200), 1);
  endtask

  // Slave model: acks after a scripted number of request2s cycles, drops
  // ack after a scripted number of valid cycles.
  initial begin : slave
    slave_t cfg;
    int     n;
    forever begin
      @(negedge clk);
      if (rst_n && request2s) begin
        if (slv_q.size() > 0) cfg = slv_q.pop_front();
        else begin cfg.rise = 0; cfg.fall = 0; end
        if (cfg.rise == 0) begin
          for (int k = 0; k < 100 && request2s; k++) @(negedge clk);
        end else begin
          n = 1;
          while (n < cfg.rise && request2s) begin @(negedge clk); n++; end
          ack = 1'b1;
          for (int k = 0; k < 100 && !valid && busy; k++) @(negedge clk);
          if (valid) begin
            n = 1;
            while (n < cfg.fall && valid) begin @(negedge clk); n++; end
          end
          ack = 1'b0;
        end
      end
    end
  end

  // Monitor: measure each transaction, compare on done / timeout_err.
  int         cyc = 0;
  int         last_end = 0;
  bit         have_prev = 1'b0;
  bit         in_txn = 1'b0;
  logic [N-1:0] m_grant;
  logic [2:0] m_data;
  int         m_r2s, m_ntc, m_vld, m_gap;

  always @(negedge clk) begin
    txn_t e;
    cyc++;
    if (!rst_n) begin
      in_txn    = 1'b0;
      have_prev = 1'b0;
    end else begin
      if (!in_txn && grant != '0) begin
        in_txn  = 1'b1;
        m_grant = grant;
        m_r2s = 0; m_ntc = 0; m_vld = 0; m_data = 'x;
        m_gap = have_prev ? (cyc - last_end) : -1;
      end
      if (in_txn) begin
        if (request2s) m_r2s++;
        if (notice)    m_ntc++;
        if (valid) begin m_vld++; m_data = data; end
      end
      if (done != '0 || timeout_err) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion: done=%b timeout_err=%b", done, timeout_err);
        end else begin
          e = exp_q.pop_front();
          check("owner_grant", m_grant, 64'(1) << e.owner);
          check("done", done, e.timed_out ? 64'(0) : (64'(1) << e.owner));
          check("timeout_err", timeout_err, e.timed_out);
          check("request2s_cycles", m_r2s, e.r2s);
          check("notice_cycles", m_ntc, e.ntc);
          check("valid_cycles", m_vld, e.vld);
          if (!e.timed_out) check("data", m_data, e.dat);
          if (e.gap >= 0) check("idle_gap", m_gap, e.gap);
          check("end_outputs_low", {grant, valid, request2s, notice, busy}, 0);
        end
        in_txn    = 1'b0;
        have_prev = 1'b1;
        last_end  = cyc;
      end else if (in_txn && !busy && grant == '0) begin
        in_txn = 1'b0;   // aborted by reset
      end
    end
  end

  initial begin : stimulus
    // Requester payloads: 0->3, 1->6, 2->5, 3->7.
    req_data = {3'd7, 3'd5, 3'd6, 3'd3};

    repeat (3) @(negedge clk);
    check("reset_outputs",
          {request2s, data, valid, notice, grant, done, timeout_err, busy}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request from requester 2, payload 5.
    expect_txn(2, 3'd5, 0, 3, HC, 2, -1, 3, 2);
    pulse(4'b0100);
    wait_idle("s1");

    // All four at once after reset: served 0,1,2,3 back to back.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    expect_txn(0, 3'd3, 0, 3, HC, 2, -1, 3, 2);
    expect_txn(1, 3'd6, 0, 3, HC, 2,  1, 3, 2);
    expect_txn(2, 3'd5, 0, 3, HC, 2,  1, 3, 2);
    expect_txn(3, 3'd7, 0, 3, HC, 2,  1, 3, 2);
    pulse(4'b1111);
    wait_idle("s2");

    // Silent slave for requester 1: timeout, then requester 3 served.
    expect_txn(1, 3'd0, 1, TOC, 0, 0, -1, 0, 0);
    expect_txn(3, 3'd7, 0, 3,   HC, 2,  1, 3, 2);
    pulse(4'b1010);
    wait_idle("s3");

    // Requester 1 pulses three times while 0 owns the link: one transaction.
    expect_txn(0, 3'd3, 0, 3, HC, 2, -1, 3, 2);
    expect_txn(1, 3'd6, 0, 3, HC, 2,  1, 3, 2);
    pulse(4'b0001);
    wait_sig(0, "s4_notice");
    pulse(4'b0010);
    @(negedge clk);
    pulse(4'b0010);
    @(negedge clk);
    pulse(4'b0010);
    wait_idle("s4");
    repeat (8) @(negedge clk);
    check("s4_no_extra_txn", busy, 0);

    // Reset during HOLD with requester 0 also pending.
    slv_q.push_back('{3, 2});
    pulse(4'b0100);
    wait_sig(0, "s5_notice");
    pulse(4'b0001);
    check("s5_in_hold", notice, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("s5_reset_outputs",
          {request2s, data, valid, notice, grant, done, timeout_err, busy}, 0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("s5_pending_cleared", {busy, grant}, 0);

    // Requester 0 re-requests during its own SEND.
    expect_txn(0, 3'd3, 0, 3, HC, 2, -1, 3, 2);
    expect_txn(0, 3'd3, 0, 3, HC, 2,  1, 3, 2);
    pulse(4'b0001);
    wait_sig(1, "s6_valid");
    pulse(4'b0001);
    wait_idle("s6");

    check("slave_queue_empty", slv_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
